sdram_arbiter: RTL and testbench

Round-robin arbiter that shares the single SDRAM controller command port among NUM_PORTS requesters, e.g. CPU instruction, CPU data, video scanout and DMA. It sits between the requesters and the SDRAM core and keeps at most one transaction outstanding. It forwards the granted requester's command when the core is ready, routes the completion pulse back to that requester, and recovers from lost completions with a watchdog.

---
 rtl/sdram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter that shares one SDRAM core command port
// among NUM_PORTS requesters, keeping at most one transaction outstanding.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_rd            per-port read request
//   req_wr            per-port write byte enables (nonzero = write request)
//   req_addr          per-port byte address, port p in slice p
//   req_write_data    per-port write data
//   req_ack           one-cycle pulse when the core accepts the port's command
//   req_rvalid/wvalid one-cycle read/write completion to the granted port
//   req_error         one-cycle error completion (core error, wrong type, watchdog)
//   req_read_data     broadcast read data, nonzero only with a read completion
//   mem_rd/wr/addr/write_data   command to the core (granted port, ISSUE only)
//   mem_rdy           core ready
//   mem_rvalid/wvalid/error, mem_read_data   completions from the core

// Per-port request detect and completion/ack steering.
module sdram_arb_port #(
    parameter int BE_W = 4
) (
    input  logic            rd,
    input  logic [BE_W-1:0] wr,
    input  logic            sel,
    input  logic            ack_in,
    input  logic            rv_in,
    input  logic            wv_in,
    input  logic            err_in,
    output logic            req,
    output logic            ack,
    output logic            rvalid,
    output logic            wvalid,
    output logic            error
);
    assign req    = rd | (|wr);
    assign ack    = sel & ack_in;
    assign rvalid = sel & rv_in;
    assign wvalid = sel & wv_in;
    assign error  = sel & err_in;
endmodule

module sdram_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_rd,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_write_data,
    output logic [NUM_PORTS-1:0]             req_ack,
    output logic [NUM_PORTS-1:0]             req_rvalid,
    output logic [NUM_PORTS-1:0]             req_wvalid,
    output logic [NUM_PORTS-1:0]             req_error,
    output logic [DATA_WIDTH-1:0]            req_read_data,
    output logic                             mem_rd,
    output logic [DATA_WIDTH/8-1:0]          mem_wr,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_write_data,
    input  logic                             mem_rdy,
    input  logic                             mem_rvalid,
    input  logic                             mem_wvalid,
    input  logic                             mem_error,
    input  logic [DATA_WIDTH-1:0]            mem_read_data
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state, nxt;
    logic [IDX_W-1:0]     grant, last, rr_pick;
    logic [WD_W-1:0]      wdog;
    logic                 is_rd;
    logic [NUM_PORTS-1:0] req_vec;
    logic                 any_req;

    // granted port's live request (mux)
    logic                  g_rd, g_req;
    logic [BE_W-1:0]       g_wr;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;

    logic accept, cmp_rv, cmp_wv, cmp_er, done, wd_exp, err;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        sdram_arb_port #(.BE_W(BE_W)) u_port (
            .rd     (req_rd[p]),
            .wr     (req_wr[p*BE_W +: BE_W]),
            .sel    (grant == IDX_W'(p)),
            .ack_in (accept),
            .rv_in  (cmp_rv),
            .wv_in  (cmp_wv),
            .err_in (err),
            .req    (req_vec[p]),
            .ack    (req_ack[p]),
            .rvalid (req_rvalid[p]),
            .wvalid (req_wvalid[p]),
            .error  (req_error[p])
        );
    end

    // Walk backwards from last+NUM_PORTS to last+1 so the port closest
    // after last is the final (winning) assignment.
    always_comb begin
        logic [IDX_W-1:0] idx;
        rr_pick = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % NUM_PORTS);
            if (req_vec[idx]) begin
                rr_pick = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        g_rd    = 1'b0;
        g_wr    = '0;
        g_addr  = '0;
        g_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == IDX_W'(p)) begin
                g_rd    = req_rd[p];
                g_wr    = req_wr[p*BE_W +: BE_W];
                g_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                g_wdata = req_write_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        g_req = g_rd | (|g_wr);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next state
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (any_req) nxt = ISSUE;
            ISSUE:   if (!g_req) nxt = IDLE;
                     else if (mem_rdy) nxt = WAIT;
                     else nxt = ISSUE;
            WAIT:    if (done | wd_exp) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // outputs; everything is gated by rst_n so outputs read 0 while in reset
    always_comb begin
        mem_rd         = 1'b0;
        mem_wr         = '0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (rst_n && state == ISSUE) begin
            mem_rd         = g_rd;
            mem_wr         = g_rd ? '0 : g_wr;   // rd wins if both are set
            mem_addr       = g_addr;
            mem_write_data = g_wdata;
        end
        accept = rst_n && state == ISSUE && mem_rdy && g_req;
        cmp_rv = rst_n && state == WAIT && mem_rvalid;
        cmp_wv = rst_n && state == WAIT && mem_wvalid;
        cmp_er = rst_n && state == WAIT && mem_error;
        done   = cmp_rv | cmp_wv | cmp_er;
        wd_exp = rst_n && state == WAIT && !done && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
        // wrong completion type still completes, but flags an error
        err    = cmp_er | wd_exp | (cmp_rv & ~is_rd) | (cmp_wv & is_rd);
        req_read_data = cmp_rv ? mem_read_data : '0;
    end

    // grant / last / watchdog / transaction type
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant <= '0;
            last  <= IDX_W'(NUM_PORTS - 1);
            wdog  <= '0;
            is_rd <= 1'b0;
        end else begin
            if (state == IDLE && any_req) grant <= rr_pick;
            if (accept) begin
                is_rd <= g_rd;
                last  <= grant;
                wdog  <= '0;
            end
            if (state == WAIT && !done) wdog <= wdog + 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (4 ports, 32-bit data, 24-bit addr,
// TIMEOUT_CYCLES=64). Inputs change 1 time unit after a rising edge and
// outputs are compared 1 unit later, well away from the next edge.
module tb_sdram_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 24;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_rd;
    logic [NP*BW-1:0]  req_wr;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_write_data;
    logic [NP-1:0]     req_ack, req_rvalid, req_wvalid, req_error;
    logic [DW-1:0]     req_read_data;
    logic              mem_rd;
    logic [BW-1:0]     mem_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_write_data;
    logic              mem_rdy, mem_rvalid, mem_wvalid, mem_error;
    logic [DW-1:0]     mem_read_data;

    int vecs = 0;
    int errs = 0;

    sdram_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_write_data(req_write_data),
        .req_ack(req_ack), .req_rvalid(req_rvalid), .req_wvalid(req_wvalid), .req_error(req_error),
        .req_read_data(req_read_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_rdy(mem_rdy), .mem_rvalid(mem_rvalid), .mem_wvalid(mem_wvalid), .mem_error(mem_error),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic rd, input logic [BW-1:0] be,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rd[p]                 = rd;
        req_wr[p*BW +: BW]        = be;
        req_addr[p*AW +: AW]      = a;
        req_write_data[p*DW +: DW] = d;
    endtask

    initial begin
        int ep;
        logic [NP-1:0] onehot;
        rst_n = 1'b0; req_rd = '0; req_wr = '0; req_addr = '0; req_write_data = '0;
        mem_rdy = 1'b1; mem_rvalid = 1'b0; mem_wvalid = 1'b0; mem_error = 1'b0; mem_read_data = '0;
        step(); step(); step();
        #1;
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);

        // single port-2 read
        rst_n = 1'b1;
        step();
        set_req(2, 1'b1, 4'h0, 24'h000100, 32'h0);
        #1 chk("idle_no_cmd", 64'(mem_rd), 64'd0);
        step();
        #1;
        chk("rd2_mem_rd", 64'(mem_rd), 64'd1);
        chk("rd2_addr", 64'(mem_addr), 64'h000100);
        chk("rd2_ack", 64'(req_ack), 64'b0100);
        step();
        set_req(2, 1'b0, 4'h0, 24'h000100, 32'h0);
        #1;
        chk("rd2_wait_ack", 64'(req_ack), 64'd0);
        chk("rd2_wait_cmd", 64'(mem_rd), 64'd0);
        mem_rvalid = 1'b1; mem_read_data = 32'hDEADBEEF;
        #1;
        chk("rd2_rvalid", 64'(req_rvalid), 64'b0100);
        chk("rd2_rdata", 64'(req_read_data), 64'hDEADBEEF);
        chk("rd2_others", 64'({req_wvalid, req_error}), 64'd0);
        step();
        mem_rvalid = 1'b0;
        #1;
        chk("rd2_done_rvalid", 64'(req_rvalid), 64'd0);
        chk("rd2_done_rdata", 64'(req_read_data), 64'd0);

        // all 4 ports writing continuously, fresh reset so port 0 wins first
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 4'hF, AW'(p * 16), 32'h11110000 + DW'(p));
        for (int i = 0; i < 6; i++) begin
            ep = i % NP;
            onehot = NP'(1) << ep;
            step();
            #1;
            chk("rr_mem_wr", 64'(mem_wr), 64'hF);
            chk("rr_wdata", 64'(mem_write_data), 64'h11110000 + 64'(ep));
            chk("rr_ack", 64'(req_ack), 64'(onehot));
            chk("rr_mem_rd", 64'(mem_rd), 64'd0);
            step();
            set_req(ep, 1'b0, 4'h0, AW'(ep * 16), 32'h11110000 + DW'(ep));
            mem_wvalid = 1'b1;
            #1;
            chk("rr_wvalid", 64'(req_wvalid), 64'(onehot));
            chk("rr_no_err", 64'(req_error), 64'd0);
            step();
            mem_wvalid = 1'b0;
            if (i < 5) set_req(ep, 1'b0, 4'hF, AW'(ep * 16), 32'h11110000 + DW'(ep));
            else begin req_rd = '0; req_wr = '0; end
        end

        // mem_rdy low for 20 cycles in ISSUE (last=1, only port 0 requests)
        mem_rdy = 1'b0;
        set_req(0, 1'b1, 4'h0, 24'h000ABC, 32'h0);
        step();
        for (int k = 0; k < 20; k++) begin
            #1 chk("stall_stable", 64'({mem_rd, mem_addr, req_ack}), 64'({1'b1, 24'h000ABC, 4'b0000}));
            step();
        end
        mem_rdy = 1'b1;
        #1 chk("stall_ack", 64'(req_ack), 64'b0001);
        step();
        set_req(0, 1'b0, 4'h0, 24'h000ABC, 32'h0);
        #1 chk("stall_ack_once", 64'(req_ack), 64'd0);
        mem_wvalid = 1'b1;           // wrong type for a read
        #1;
        chk("wrongtype_wvalid", 64'(req_wvalid), 64'b0001);
        chk("wrongtype_err", 64'(req_error), 64'b0001);
        step();
        mem_wvalid = 1'b0;

        // watchdog: port 3 write never completes
        set_req(3, 1'b0, 4'h3, 24'h000040, 32'h0000CAFE);
        step();
        #1;
        chk("wd_ack", 64'(req_ack), 64'b1000);
        chk("wd_mem_wr", 64'(mem_wr), 64'h3);
        step();
        set_req(3, 1'b0, 4'h0, 24'h000040, 32'h0000CAFE);
        for (int k = 1; k < 64; k++) begin
            #1 chk("wd_quiet", 64'(req_error), 64'd0);
            step();
        end
        #1 chk("wd_err", 64'(req_error), 64'b1000);
        step();
        #1 chk("wd_err_once", 64'(req_error), 64'd0);
        set_req(1, 1'b1, 4'h0, 24'h000200, 32'h0);
        step();
        #1;
        chk("post_wd_ack", 64'(req_ack), 64'b0010);
        chk("post_wd_rd", 64'(mem_rd), 64'd1);
        step();
        set_req(1, 1'b0, 4'h0, 24'h000200, 32'h0);
        mem_error = 1'b1;
        #1;
        chk("core_err", 64'(req_error), 64'b0010);
        chk("core_err_rv", 64'(req_rvalid), 64'd0);
        step();
        mem_error = 1'b0;

        // reset while in WAIT
        set_req(2, 1'b1, 4'h0, 24'h000300, 32'h0);
        step();
        #1 chk("rst_wait_ack", 64'(req_ack), 64'b0100);
        step();
        set_req(2, 1'b0, 4'h0, 24'h000300, 32'h0);
        rst_n = 1'b0;
        step();
        mem_rvalid = 1'b1; mem_read_data = 32'h12345678;
        #1;
        chk("rst_wait_rv", 64'(req_rvalid), 64'd0);
        chk("rst_wait_rdata", 64'(req_read_data), 64'd0);
        chk("rst_wait_outs", 64'({mem_rd, mem_wr, req_ack, req_error}), 64'd0);
        step();
        rst_n = 1'b1;
        #1 chk("idle_cmp_ignored", 64'(req_rvalid), 64'd0);
        step();
        mem_rvalid = 1'b0;
        set_req(0, 1'b1, 4'h0, 24'h000400, 32'h0);
        set_req(1, 1'b1, 4'h0, 24'h000500, 32'h0);
        set_req(3, 1'b1, 4'h0, 24'h000700, 32'h0);
        step();
        #1;
        chk("rst_first_grant", 64'(req_ack), 64'b0001);
        chk("rst_first_addr", 64'(mem_addr), 64'h000400);
        step();
        set_req(0, 1'b0, 4'h0, 24'h000400, 32'h0);
        mem_rvalid = 1'b1; mem_read_data = 32'h00000055;
        #1;
        chk("p0_rvalid", 64'(req_rvalid), 64'b0001);
        chk("p0_rdata", 64'(req_read_data), 64'h55);
        step();
        mem_rvalid = 1'b0;
        mem_rdy = 1'b0;

        // port 1 withdraws in ISSUE; last stays at 0 so port 1 wins again over port 3
        step();
        #1;
        chk("wd1_addr", 64'(mem_addr), 64'h000500);
        chk("wd1_no_ack", 64'(req_ack), 64'd0);
        set_req(1, 1'b0, 4'h0, 24'h000500, 32'h0);
        #1 chk("wd1_withdrawn", 64'({mem_rd, req_ack}), 64'd0);
        step();
        set_req(1, 1'b1, 4'h0, 24'h000500, 32'h0);
        mem_rdy = 1'b1;
        #1 chk("wd1_idle", 64'({mem_rd, req_ack}), 64'd0);
        step();
        #1;
        chk("wd1_regrant", 64'(req_ack), 64'b0010);
        chk("wd1_regrant_addr", 64'(mem_addr), 64'h000500);
        step();
        req_rd = '0; req_wr = '0;
        mem_rvalid = 1'b1; mem_read_data = 32'hA5A5A5A5;
        #1 chk("wd1_rvalid", 64'(req_rvalid), 64'b0010);
        step();
        mem_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
